tmr32_capture_fifo: RTL and testbench

- Sits directly downstream of the TMR32 timer's capture path.
- Each capture event (TMR32 EEVF flag set, CAPTURE holding the value) is pushed into a FIFO and acknowledged by pulsing TMR32's EEVF_CLR.
- A bus/register front-end drains the FIFO, so back-to-back external edges are not lost while software is slow.

---
 rtl/tmr32_capture_fifo.sv | 79 +++++++
 tb/tb_tmr32_capture_fifo.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/tmr32_capture_fifo.sv
// tmr32_capture_fifo: queues TMR32 capture values in a first-word-fall-through FIFO
// and acknowledges each capture event with a one-cycle EEVF_CLR pulse.
module tmr32_capture_fifo #(
  parameter int DEPTH = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          EN,
  input  logic [31:0]   CAPTURE,
  input  logic          EEVF,
  output logic          EEVF_CLR,
  input  logic          RD_EN,
  output logic [31:0]   RD_DATA,
  output logic          EMPTY,
  output logic          FULL,
  output logic [CW-1:0] COUNT,
  output logic          OVR,
  input  logic          OVR_CLR,
  input  logic          FLUSH,
  output logic          IRQ
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic empty_q, empty_d, full_q, full_d, ovr_q, ovr_d, eevf_clr_q, eevf_clr_d;
  logic push_try, pop_ok, push_ok, wr_en;
  logic [31:0] mem [DEPTH];
  always_comb begin
    push_try = (state_q == IDLE) & EN & EEVF;
    state_d = (state_q == IDLE) ? (push_try ? ACK : IDLE) :
              (state_q == ACK) ? WAIT : (EEVF ? WAIT : IDLE);
    pop_ok = RD_EN & ~empty_q;
    // a pop frees a slot in the same cycle, so a full FIFO still accepts the push
    push_ok = push_try & (~full_q | pop_ok);
    wr_en = push_ok & ~FLUSH;
    wr_ptr_d = FLUSH ? '0 : wr_ptr_q + AW'(push_ok);
    rd_ptr_d = FLUSH ? '0 : rd_ptr_q + AW'(pop_ok);
    count_d = FLUSH ? '0 : count_q + CW'(push_ok) - CW'(pop_ok);
    empty_d = count_d == '0;
    full_d = count_d == FULL_CNT;
    ovr_d = (push_try & ~push_ok & ~FLUSH) | (ovr_q & ~OVR_CLR);
    eevf_clr_d = push_try;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      ovr_q <= 1'b0;
      eevf_clr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q <= full_d;
      ovr_q <= ovr_d;
      eevf_clr_q <= eevf_clr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= CAPTURE;
  end
  assign EEVF_CLR = eevf_clr_q;
  assign EMPTY = empty_q;
  assign FULL = full_q;
  assign COUNT = count_q;
  assign OVR = ovr_q;
  assign IRQ = ~empty_q | ovr_q;
  assign RD_DATA = empty_q ? '0 : mem[rd_ptr_q];
endmodule

// File: tb/tb_tmr32_capture_fifo.sv
// tb_tmr32_capture_fifo: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the capture FIFO.
module tb_tmr32_capture_fifo;
  localparam int DEPTH = 8;
  localparam int CW = 4;
  logic clk = 1'b0;
  logic rst, EN, EEVF, RD_EN, OVR_CLR, FLUSH;
  logic [31:0] CAPTURE;
  logic EEVF_CLR, EMPTY, FULL, OVR, IRQ;
  logic [31:0] RD_DATA;
  logic [CW-1:0] COUNT;
  int checks = 0, errors = 0, clr_cnt = 0;
  logic [31:0] q[$];
  bit m_ovr, m_clr, m_armed, m_skip;

  always #5 clk = ~clk;

  tmr32_capture_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .EN(EN), .CAPTURE(CAPTURE), .EEVF(EEVF), .EEVF_CLR(EEVF_CLR),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .EMPTY(EMPTY), .FULL(FULL), .COUNT(COUNT),
    .OVR(OVR), .OVR_CLR(OVR_CLR), .FLUSH(FLUSH), .IRQ(IRQ)
  );

  typedef struct {
    bit r, e, v, rd;
    logic [31:0] c;
    int cnt;
    bit clr;
    logic [31:0] data;
    bit irq;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state changes for one clock edge, from the inputs present at that edge
  task automatic model_edge();
    bit cap, pop, drop;
    if (rst) begin
      q.delete();
      m_ovr = 0; m_clr = 0; m_armed = 1; m_skip = 0;
      return;
    end
    cap = m_armed && EN && EEVF;
    pop = RD_EN && q.size() > 0;
    drop = 0;
    m_clr = cap;
    if (FLUSH) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (cap) begin
        if (q.size() < DEPTH) q.push_back(CAPTURE);
        else drop = 1;
      end
    end
    if (drop) m_ovr = 1;
    else if (OVR_CLR) m_ovr = 0;
    if (cap) begin m_armed = 0; m_skip = 1; end
    else if (m_skip) m_skip = 0;
    else if (!m_armed && !EEVF) m_armed = 1;
  endtask

  task automatic compare_model();
    chk("count", COUNT, q.size());
    chk("empty", EMPTY, q.size() == 0);
    chk("full", FULL, q.size() == DEPTH);
    chk("rd_data", RD_DATA, q.size() > 0 ? q[0] : 32'h0);
    chk("ovr", OVR, m_ovr);
    chk("eevf_clr", EEVF_CLR, m_clr);
    chk("irq", IRQ, q.size() != 0 || m_ovr);
  endtask

  task automatic cyc(bit r, bit e, bit v, logic [31:0] c, bit rd, bit fl, bit oc);
    rst = r; EN = e; EEVF = v; CAPTURE = c; RD_EN = rd; FLUSH = fl; OVR_CLR = oc;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
    if (EEVF_CLR) clr_cnt++;
  endtask

  task automatic ev(logic [31:0] val);
    cyc(0, 1, 1, val, 0, 0, 0);
    cyc(0, 1, 1, val, 0, 0, 0);
    cyc(0, 1, 0, val, 0, 0, 0);
  endtask

  task automatic pop1();
    cyc(0, 1, 0, 0, 1, 0, 0);
  endtask

  initial begin
    tbl[0] = '{1, 0, 0, 0, 32'h0, 0, 0, 32'h0, 0};
    tbl[1] = '{0, 1, 1, 0, 32'h1234, 1, 1, 32'h1234, 1};
    tbl[2] = '{0, 1, 0, 0, 32'h0, 1, 0, 32'h1234, 1};
    tbl[3] = '{0, 1, 0, 0, 32'h0, 1, 0, 32'h1234, 1};
    tbl[4] = '{0, 1, 0, 1, 32'h0, 0, 0, 32'h0, 0};
    tbl[5] = '{0, 1, 0, 1, 32'h0, 0, 0, 32'h0, 0};
    tbl[6] = '{0, 1, 0, 0, 32'h0, 0, 0, 32'h0, 0};
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].c, tbl[i].rd, 0, 0);
      chk($sformatf("vec%0d_count", i), COUNT, tbl[i].cnt);
      chk($sformatf("vec%0d_clr", i), EEVF_CLR, tbl[i].clr);
      chk($sformatf("vec%0d_data", i), RD_DATA, tbl[i].data);
      chk($sformatf("vec%0d_irq", i), IRQ, tbl[i].irq);
    end

    clr_cnt = 0;
    for (int i = 1; i <= 8; i++) ev(i);
    chk("fill_count", COUNT, 8);
    chk("fill_full", FULL, 1);
    chk("fill_clr_pulses", clr_cnt, 8);
    clr_cnt = 0;
    ev(9);
    chk("drop_ovr", OVR, 1);
    chk("drop_full", FULL, 1);
    chk("drop_clr_pulses", clr_cnt, 1);
    for (int i = 1; i <= 8; i++) begin
      chk("pop_order", RD_DATA, i);
      pop1();
    end
    chk("drained_empty", EMPTY, 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    chk("ovr_cleared", OVR, 0);

    for (int i = 1; i <= 8; i++) ev(i);
    cyc(0, 1, 1, 32'hAA, 1, 0, 0);
    cyc(0, 1, 1, 32'hAA, 0, 0, 0);
    cyc(0, 1, 0, 32'hAA, 0, 0, 0);
    chk("pushpop_count", COUNT, 8);
    chk("pushpop_ovr", OVR, 0);
    for (int i = 2; i <= 8; i++) begin
      chk("wrap_order", RD_DATA, i);
      pop1();
    end
    chk("wrap_last", RD_DATA, 32'hAA);
    pop1();
    chk("wrap_empty", EMPTY, 1);

    clr_cnt = 0;
    repeat (20) cyc(0, 0, 1, 32'h55, 0, 0, 0);
    chk("en0_count", COUNT, 0);
    chk("en0_clr_pulses", clr_cnt, 0);
    repeat (3) cyc(0, 1, 1, 32'h66, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    chk("en1_count", COUNT, 1);
    chk("en1_clr_pulses", clr_cnt, 1);
    chk("en1_data", RD_DATA, 32'h66);
    pop1();

    for (int i = 1; i <= 3; i++) ev(i);
    cyc(0, 1, 0, 0, 1, 1, 0);
    chk("flush_count", COUNT, 0);
    chk("flush_empty", EMPTY, 1);
    for (int i = 1; i <= 8; i++) ev(i + 10);
    cyc(0, 1, 1, 32'hBB, 0, 0, 1);
    chk("ovr_set_wins", OVR, 1);
    cyc(0, 1, 1, 32'hBB, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 1, 1);
    chk("ovr_clr_flush", OVR, 0);

    for (int i = 1; i <= 4; i++) ev(i + 20);
    cyc(0, 1, 1, 32'h77, 0, 0, 0);
    cyc(0, 1, 1, 32'h77, 0, 0, 0);
    cyc(0, 1, 1, 32'h77, 0, 0, 0);
    chk("wait_count", COUNT, 5);
    cyc(1, 1, 1, 32'h88, 0, 0, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_clr", EEVF_CLR, 0);
    chk("rst_irq", IRQ, 0);
    chk("rst_data", RD_DATA, 0);
    cyc(0, 1, 1, 32'h88, 0, 0, 0);
    chk("recap_count", COUNT, 1);
    chk("recap_clr", EEVF_CLR, 1);
    chk("recap_data", RD_DATA, 32'h88);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cyc($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0,
          $urandom, (n < 1500) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0),
          $urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
